// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the slave side; the byte source / memory side uses master.
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_wr_en;
   logic [31:0] imem_wr_addr;
   logic [31:0] imem_wr_data;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them to consecutive
// instruction-memory addresses and holds the core in reset until the image is loaded.
//
//   state | meaning
//   IDLE  | no load active, core held, bytes refused
//   LOAD  | accepting bytes, one write per four accepted bytes
//   DONE  | image complete, core released, bytes refused
module imem_loader #(
   parameter int NUM_WORDS  = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          load_done,
   output logic [31:0]   checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [23:0]           partial;
   logic [31:0]           word;
   logic                  clear, discard, accept, write_word;

   assign word           = {bus.byte_data, partial};
   assign bus.byte_ready = (state_q == LOAD);
   assign cpu_hold       = (state_q != DONE);
   assign load_done      = (state_q == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      clear      = 1'b0;
      discard    = 1'b0;
      accept     = 1'b0;
      write_word = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               clear   = 1'b1;
            end
         end
         LOAD: begin
            // abort wins even over a completing byte 3
            if (abort) begin
               state_d = IDLE;
               discard = 1'b1;
            end else if (bus.byte_valid) begin
               accept = 1'b1;
               if (byte_cnt == 2'd3) begin
                  write_word = 1'b1;
                  if (word_idx == LAST_IDX) state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt         <= 2'd0;
         word_idx         <= '0;
         partial          <= 24'd0;
         bus.imem_wr_en   <= 1'b0;
         bus.imem_wr_addr <= 32'd0;
         bus.imem_wr_data <= 32'd0;
         checksum         <= 32'd0;
      end else begin
         bus.imem_wr_en <= write_word;
         if (clear) begin
            byte_cnt <= 2'd0;
            word_idx <= '0;
            checksum <= 32'd0;
         end else if (discard) begin
            byte_cnt <= 2'd0;
         end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    partial[7:0]   <= bus.byte_data;
               2'd1:    partial[15:8]  <= bus.byte_data;
               2'd2:    partial[23:16] <= bus.byte_data;
               default: ;
            endcase
            if (write_word) begin
               bus.imem_wr_addr <= 32'(word_idx);
               bus.imem_wr_data <= word;
               checksum         <= checksum ^ word;
               word_idx         <= word_idx + ADDR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a one-word and a four-word instance, each with
// a monitor that pops expected writes whenever a write strobe appears.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_a, abort_a, start_b, abort_b;
   logic        hold_a, done_a, hold_b, done_b;
   logic [31:0] ck_a, ck_b;

   imem_loader_if ai();
   imem_loader_if bi();

   imem_loader #(.NUM_WORDS(1), .ADDR_WIDTH(8)) u_one (
      .clk(clk), .reset(rst), .start(start_a), .abort(abort_a), .bus(ai),
      .cpu_hold(hold_a), .load_done(done_a), .checksum(ck_a));

   imem_loader #(.NUM_WORDS(4), .ADDR_WIDTH(8)) u_four (
      .clk(clk), .reset(rst), .start(start_b), .abort(abort_b), .bus(bi),
      .cpu_hold(hold_b), .load_done(done_b), .checksum(ck_b));

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          last;
      int          gap;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;
   int   last_a = 0;
   int   last_b = 0;

   logic [31:0] img [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
   logic [31:0] exp_ck;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ai.imem_wr_en === 1'b1) begin
         if (qa.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL a_unexpected_strobe: got addr %h data %h, expected no strobe",
                     ai.imem_wr_addr, ai.imem_wr_data);
         end else begin
            ea = qa.pop_front();
            chk32("a_addr", ai.imem_wr_addr, ea.addr);
            chk32("a_data", ai.imem_wr_data, ea.data);
            chk1("a_done_at_strobe", done_a, ea.last);
            chk1("a_hold_at_strobe", hold_a, !ea.last);
         end
         last_a = cycle;
      end
   end

   always @(negedge clk) begin
      if (bi.imem_wr_en === 1'b1) begin
         if (qb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL b_unexpected_strobe: got addr %h data %h, expected no strobe",
                     bi.imem_wr_addr, bi.imem_wr_data);
         end else begin
            eb = qb.pop_front();
            chk32("b_addr", bi.imem_wr_addr, eb.addr);
            chk32("b_data", bi.imem_wr_data, eb.data);
            chk1("b_done_at_strobe", done_b, eb.last);
            chk1("b_hold_at_strobe", hold_b, !eb.last);
            chk1("b_ready_at_strobe", bi.byte_ready, !eb.last);
            if (eb.gap != 0) chk32("b_strobe_gap", 32'(cycle - last_b), 32'(eb.gap));
         end
         last_b = cycle;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic [7:0] b);
      chk1("b_ready_before_byte", bi.byte_ready, 1'b1);
      bi.byte_valid = 1'b1;
      bi.byte_data  = b;
      tick();
   endtask

   task automatic wait_drain(input bit which_b);
      int n = 0;
      while (((which_b ? qb.size() : qa.size()) != 0) && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if ((which_b ? qb.size() : qa.size()) != 0) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d writes outstanding, expected 0",
                  which_b ? "b" : "a", which_b ? qb.size() : qa.size());
      end
   endtask

   task automatic chk_reset_b();
      chk1("rst_ready", bi.byte_ready, 1'b0);
      chk1("rst_wr_en", bi.imem_wr_en, 1'b0);
      chk32("rst_addr", bi.imem_wr_addr, 32'd0);
      chk32("rst_data", bi.imem_wr_data, 32'd0);
      chk1("rst_done", done_b, 1'b0);
      chk1("rst_hold", hold_b, 1'b1);
      chk32("rst_checksum", ck_b, 32'd0);
   endtask

   logic [7:0] bytes_a [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
   logic [7:0] bytes_c [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

   initial begin
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      ai.byte_valid = 1'b0; ai.byte_data = 8'h00;
      bi.byte_valid = 1'b0; bi.byte_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_b();
      chk1("rst_hold_a", hold_a, 1'b1);
      rst = 1'b0;
      tick();

      // idle with valid high: nothing may be accepted or written
      ai.byte_valid = 1'b1; ai.byte_data = 8'h5A;
      bi.byte_valid = 1'b1; bi.byte_data = 8'h5A;
      repeat (20) begin
         tick();
         chk1("idle_ready", bi.byte_ready, 1'b0);
         chk1("idle_hold", hold_b, 1'b1);
         chk1("idle_done", done_b, 1'b0);
      end
      ai.byte_valid = 1'b0;
      bi.byte_valid = 1'b0;

      // one-word image
      qa.push_back('{32'd0, 32'h12345678, 1'b1, 0});
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("a_ready_before_byte", ai.byte_ready, 1'b1);
         ai.byte_valid = 1'b1;
         ai.byte_data  = bytes_a[i];
         tick();
      end
      ai.byte_valid = 1'b0;
      wait_drain(1'b0);
      chk32("a_checksum", ck_a, 32'h12345678);
      chk1("a_done", done_a, 1'b1);
      chk1("a_hold", hold_a, 1'b0);

      // four-word image, continuous valid
      exp_ck = 32'd0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int w = 0; w < 4; w++) begin
         qb.push_back('{32'(w), img[w], (w == 3), (w == 0) ? 0 : 4});
         exp_ck = exp_ck ^ img[w];
      end
      for (int i = 0; i < 16; i++) send_b(8'(i));
      bi.byte_valid = 1'b0;
      wait_drain(1'b1);
      chk32("cont_checksum", ck_b, exp_ck);
      chk1("cont_done", done_b, 1'b1);
      chk1("cont_hold", hold_b, 1'b0);
      chk1("cont_ready", bi.byte_ready, 1'b0);

      // DONE ignores bytes and abort; write port holds its last value
      bi.byte_valid = 1'b1; bi.byte_data = 8'hEE;
      abort_b = 1'b1;
      repeat (3) tick();
      abort_b = 1'b0;
      bi.byte_valid = 1'b0;
      chk1("done_abort_ignored", done_b, 1'b1);
      chk32("done_addr_hold", bi.imem_wr_addr, 32'd3);
      chk32("done_data_hold", bi.imem_wr_data, img[3]);

      // reload from DONE
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk1("reload_done", done_b, 1'b0);
      chk1("reload_hold", hold_b, 1'b1);
      chk32("reload_checksum", ck_b, 32'd0);
      chk1("reload_ready", bi.byte_ready, 1'b1);

      // stalled handshake: valid every other cycle
      exp_ck = 32'd0;
      for (int w = 0; w < 4; w++) begin
         qb.push_back('{32'(w), img[w], (w == 3), (w == 0) ? 0 : 8});
         exp_ck = exp_ck ^ img[w];
      end
      for (int i = 0; i < 16; i++) begin
         send_b(8'(i));
         bi.byte_valid = 1'b0;
         bi.byte_data  = 8'hFF;
         tick();
      end
      wait_drain(1'b1);
      chk32("stall_checksum", ck_b, exp_ck);
      chk1("stall_done", done_b, 1'b1);

      // abort together with a completing byte 3
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      send_b(8'h11);
      send_b(8'h22);
      send_b(8'h33);
      abort_b = 1'b1;
      send_b(8'h44);
      abort_b = 1'b0;
      bi.byte_valid = 1'b0;
      chk1("abort_ready", bi.byte_ready, 1'b0);
      chk1("abort_hold", hold_b, 1'b1);
      chk1("abort_done", done_b, 1'b0);
      repeat (2) tick();

      // fresh load after abort starts from byte 0, address 0
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      qb.push_back('{32'd0, 32'hDDCCBBAA, 1'b0, 0});
      for (int i = 0; i < 4; i++) send_b(bytes_c[i]);
      bi.byte_valid = 1'b0;
      wait_drain(1'b1);
      chk32("after_abort_checksum", ck_b, 32'hDDCCBBAA);
      chk1("after_abort_hold", hold_b, 1'b1);

      // async reset mid-word
      send_b(8'h01);
      send_b(8'h02);
      #2 rst = 1'b1;
      #1;
      chk_reset_b();
      bi.byte_valid = 1'b1; bi.byte_data = 8'h03;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk1("post_rst_ready", bi.byte_ready, 1'b0);
      chk1("post_rst_hold", hold_b, 1'b1);
      chk32("post_rst_checksum", ck_b, 32'd0);
      bi.byte_valid = 1'b0;
      repeat (2) tick();

      wait_drain(1'b0);
      wait_drain(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
